// File: rtl/enemy_tank_controller.sv
// Enemy tank movement/fire scheduler.
// Frame-paced wander, collision turns, periodic shots, death and respawn.
module enemy_tank_controller #(
  parameter int unsigned SPAWN_DELAY     = 60,
  parameter int unsigned MOVE_FRAMES_MIN = 32,
  parameter int unsigned TURN_PAUSE      = 4,
  parameter int unsigned FIRE_PERIOD     = 45,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic enable,
  input  logic collision,
  input  logic was_hit,
  input  logic fire_ack,
  output logic up_direction,
  output logic down_direction,
  output logic right_direction,
  output logic left_direction,
  output logic fire_req,
  output logic alive
);

  typedef enum logic [1:0] {
    S_SPAWN,
    S_MOVE,
    S_TURN,
    S_DEAD
  } state_t;

  localparam logic [7:0]  P_SPAWN = 8'(SPAWN_DELAY);
  localparam logic [7:0]  P_MOVE  = 8'(MOVE_FRAMES_MIN);
  localparam logic [7:0]  P_TURN  = 8'(TURN_PAUSE);
  localparam logic [7:0]  P_FIRE  = 8'(FIRE_PERIOD);
  localparam logic [15:0] P_TAPS  = 16'hB400;
  localparam logic [1:0]  D_DOWN  = 2'b01;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_run;
  logic [7:0]  r_fire_cnt;
  logic [1:0]  r_dir;
  logic        r_col_turn;
  logic [15:0] r_lfsr;
  logic [3:0]  r_dirs;
  logic        r_fire_req;
  logic        r_alive;

  logic        w_tick;
  logic [7:0]  w_cnt_inc;
  logic [7:0]  w_fire_inc;
  logic [15:0] w_lfsr_next;
  logic [7:0]  w_run_len;
  logic [1:0]  w_rnd_dir;
  logic [1:0]  w_turn_dir;
  logic        w_fire_tick;
  logic        w_fire_exp;

  // Direction code to {up,down,right,left}.
  function automatic logic [3:0] f_onehot(input logic [1:0] d);
    logic [3:0] v;
    v = 4'b0000;
    unique case (d)
      2'b00: v = 4'b1000;
      2'b01: v = 4'b0100;
      2'b10: v = 4'b0010;
      2'b11: v = 4'b0001;
    endcase
    return v;
  endfunction

  assign w_tick      = startOfFrame & enable;
  assign w_cnt_inc   = r_cnt + 8'd1;
  assign w_fire_inc  = r_fire_cnt + 8'd1;
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ P_TAPS)
                                 : (r_lfsr >> 1);
  assign w_run_len   = P_MOVE + {2'b00, r_lfsr[5:2], 2'b00};
  assign w_rnd_dir   = r_lfsr[1:0];
  assign w_turn_dir  = (r_col_turn && (w_rnd_dir == r_dir))
                     ? r_dir + 2'd1 : w_rnd_dir;
  // Only frames that stay in MOVE feed the fire timer.
  assign w_fire_tick = w_tick && (r_state == S_MOVE)
                     && !was_hit && !collision;
  assign w_fire_exp  = w_fire_tick && (w_fire_inc == P_FIRE);

  assign up_direction    = r_dirs[3];
  assign down_direction  = r_dirs[2];
  assign right_direction = r_dirs[1];
  assign left_direction  = r_dirs[0];
  assign fire_req        = r_fire_req;
  assign alive           = r_alive;

  // Tank FSM with frame, run, fire counters and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_SPAWN;
      r_cnt      <= '0;
      r_run      <= '0;
      r_fire_cnt <= '0;
      r_dir      <= D_DOWN;
      r_col_turn <= 1'b0;
      r_lfsr     <= LFSR_SEED;
      r_dirs     <= '0;
      r_fire_req <= 1'b0;
      r_alive    <= 1'b0;
    end else if (!enable) begin
      r_dirs <= '0;
    end else begin
      r_lfsr <= w_lfsr_next;
      if (w_fire_tick) begin
        r_fire_cnt <= w_fire_exp ? 8'd0 : w_fire_inc;
      end
      if (w_fire_exp) begin
        r_fire_req <= 1'b1;
      end else if (fire_ack) begin
        r_fire_req <= 1'b0;
      end
      unique case (r_state)
        S_SPAWN: begin
          r_alive    <= 1'b0;
          r_dirs     <= '0;
          r_fire_req <= 1'b0;
          r_fire_cnt <= '0;
          if (w_tick) begin
            if (w_cnt_inc == P_SPAWN) begin
              r_state <= S_MOVE;
              r_cnt   <= '0;
              r_dir   <= D_DOWN;
              r_run   <= w_run_len;
              r_alive <= 1'b1;
              r_dirs  <= f_onehot(D_DOWN);
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_MOVE: begin
          if (was_hit) begin
            r_state    <= S_DEAD;
            r_cnt      <= '0;
            r_alive    <= 1'b0;
            r_dirs     <= '0;
            r_fire_req <= 1'b0;
            r_fire_cnt <= '0;
          end else if (collision) begin
            r_state    <= S_TURN;
            r_col_turn <= 1'b1;
            r_cnt      <= '0;
            r_dirs     <= '0;
          end else if (w_tick && (w_cnt_inc == r_run)) begin
            r_state    <= S_TURN;
            r_col_turn <= 1'b0;
            r_cnt      <= '0;
            r_dirs     <= '0;
          end else begin
            if (w_tick) begin
              r_cnt <= w_cnt_inc;
            end
            r_dirs <= f_onehot(r_dir);
          end
        end
        S_TURN: begin
          if (was_hit) begin
            r_state    <= S_DEAD;
            r_cnt      <= '0;
            r_alive    <= 1'b0;
            r_dirs     <= '0;
            r_fire_req <= 1'b0;
            r_fire_cnt <= '0;
          end else begin
            r_dirs <= '0;
            if (w_tick) begin
              if (w_cnt_inc == P_TURN) begin
                r_state <= S_MOVE;
                r_cnt   <= '0;
                r_dir   <= w_turn_dir;
                r_run   <= w_run_len;
                r_dirs  <= f_onehot(w_turn_dir);
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end
        end
        S_DEAD: begin
          r_state    <= S_SPAWN;
          r_cnt      <= '0;
          r_alive    <= 1'b0;
          r_dirs     <= '0;
          r_fire_req <= 1'b0;
          r_fire_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/enemy_tank_controller.md
Name: enemy_tank_controller

Overview:
Per-tank movement/fire scheduler for computer-controlled tanks. Drives the four direction inputs and the collision path of one tank-movement instance, choosing pseudo-random headings, turning away from walls on collision, requesting shots periodically, and handling death/respawn. One instance per enemy tank. Frame-rate timing comes from the shared startOfFrame pulse.

Parameters:
SPAWN_DELAY, 60, frames from reset/death until the tank appears and moves (1..255)
MOVE_FRAMES_MIN, 32, minimum frames per straight run (1..195)
TURN_PAUSE, 4, frames with no direction asserted between runs (1..255)
FIRE_PERIOD, 45, frames in MOVE between fire requests (1..255)
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous active-low reset
startOfFrame  input  1  one-clock pulse per video frame
enable  input  1  1 = run; 0 = freeze (game paused)
collision  input  1  tank/brick or tank/tank collision, same signal fed to the movement block
was_hit  input  1  one-clock pulse: this tank destroyed by player shot
fire_ack  input  1  one-clock pulse: shot launcher accepted the request
up_direction  output  1  move up
down_direction  output  1  move down
right_direction  output  1  move right
left_direction  output  1  move left
fire_req  output  1  shot request, level, held until fire_ack
alive  output  1  tank visible/active

Behaviour:
- Reset (async, resetN=0): state=SPAWN, all counters 0, dir code=01 (down), LFSR=LFSR_SEED; all outputs 0.
- Direction outputs are registered, one-hot or all-zero; never two asserted. Encoding of dir code: 00 up, 01 down, 10 right, 11 left.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every clk while enable=1 (not only on frames).
- Frame counter: 8-bit, increments only on startOfFrame with enable=1; cleared on every state change.
- SPAWN: alive=0, directions 0, fire_req 0. When counter reaches SPAWN_DELAY -> MOVE with dir=down, run length loaded, fire counter cleared; alive=1 and down_direction=1 the cycle after the SPAWN_DELAY-th frame pulse.
- MOVE: alive=1, direction output = current dir code. Run length = MOVE_FRAMES_MIN + 4*lfsr[5:2] frames (latched on entry; max 255). Counter reaches run length -> TURN (reason=timeout). collision=1 in any cycle -> TURN next clk (reason=collision); directions 0 on that edge.
- TURN: directions 0, alive=1. After TURN_PAUSE frames: new dir = lfsr[1:0]; if reason=collision and new dir equals previous dir, new dir = previous+1 mod 4. -> MOVE with new run length.
- DEAD: entered from MOVE or TURN when was_hit=1; lasts exactly one clock; alive=0, directions 0, fire_req 0; -> SPAWN with counter cleared. was_hit in SPAWN or DEAD ignored.
- Fire: 8-bit fire counter counts frames in MOVE only (holds in TURN). At FIRE_PERIOD sets fire_req=1 and clears counter. fire_req stays 1 through MOVE/TURN until fire_ack; cleared the clock after fire_ack. fire_ack with fire_req=0 ignored. Counter keeps running while request pending; a second expiry while pending is dropped.
- enable=0: state, counters, LFSR frozen; directions forced 0 combinationally-registered next cycle; fire_req and alive hold. Resume continues exactly where frozen.
- Priority in one cycle: resetN > was_hit > collision > frame-count expiry. Collision and startOfFrame coincident: go to TURN, frame not counted.
- Reset mid-operation returns to SPAWN state immediately, regardless of pending fire_req.

Test Plan:
- Release reset, 60 frame pulses -> all outputs 0 through pulse 60; cycle after pulse 60 alive=1, down_direction=1, others 0.
- In MOVE down, assert collision 1 clk -> all directions 0 next clk; after 4 frames exactly one direction asserted and it is not down.
- Force LFSR_SEED so run length = 32: no collision -> direction drops to 0 after exactly 32 frames, new direction after 4 more.
- 45 frames in MOVE -> fire_req=1; hold fire_ack low 10 frames -> fire_req stays 1; pulse fire_ack -> fire_req 0 next clk; next request 45 MOVE frames after previous expiry.
- was_hit and collision same clk during MOVE with fire_req=1 -> DEAD one clk (alive=0, fire_req=0, directions 0), then SPAWN; reappears after 60 frames moving down.
- enable=0 for 20 frames mid-MOVE -> directions 0, counters frozen; enable=1 -> same direction resumes and run ends at original remaining count. Assert one-hot/zero on directions in every test.
